conv2d_stream: RTL and testbench
================================

Name: conv2d_stream

Overview:
- Parametrised successor of the fixed 8x8 / 3x3 convolution processor.
- Accepts one image frame of IMG_H x IMG_W unsigned pixels over a valid/ready stream and stores it in an internal frame buffer.
- Convolves the frame with a runtime-writable 3x3 fixed-point kernel, one output per cycle through a 2-stage pipeline.
- Streams results out under valid/ready backpressure; sits between the pixel source and the downstream feature consumer.

Parameters:
- DATA_W, 8: pixel width, unsigned.
- COEF_W, 8: kernel coefficient width, unsigned.
- IMG_W, 8: frame width in pixels, minimum 3.
- IMG_H, 8: frame height in pixels, minimum 3.
- SHIFT, 0: right shift applied to the accumulated sum (fixed-point scaling).
- OUT_W, 16: output width; shifted result saturates to this width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_st  in  1  frame start pulse; honoured only in IDLE.
- din  in  DATA_W  pixel, raster order.
- din_vld  in  1  pixel valid.
- din_rdy  out  1  high only in LOAD.
- k_wr  in  1  kernel coefficient write strobe.
- k_addr  in  4  coefficient index 0..8, row-major.
- k_data  in  COEF_W  coefficient value.
- dout  out  OUT_W  convolution result.
- dout_vld  out  1  result valid.
- dout_rdy  in  1  downstream ready.
- out_st  out  1  high with the first result of a frame.
- frame_done  out  1  one-cycle pulse after the last result transfers.

Behaviour:
- Reset: state IDLE; din_rdy, dout_vld, out_st, frame_done = 0; dout = 0; counters cleared; kernel reloaded with 8,16,8,16,32,16,8,16,8.
- Reset mid-frame aborts immediately; partial buffer contents are discarded.
- IDLE: in_st=1 -> LOAD next cycle; din_rdy rises that cycle.
- LOAD: a pixel is written on each din_vld & din_rdy. After IMG_W*IMG_H pixels: din_rdy drops the same edge, -> CONV. in_st is ignored.
- CONV, stage 1: window at (r,c) read; 9 products of width DATA_W+COEF_W registered.
- CONV, stage 2: products summed at width DATA_W+COEF_W+4, shifted right by SHIFT, saturated to 2^OUT_W-1, registered into dout with dout_vld=1.
- Scan order: r = 0..IMG_H-3, c = 0..IMG_W-3, raster. First dout_vld arrives 2 cycles after entering CONV.
- Stall rule: dout_vld=1 & dout_rdy=0 freezes both pipeline stages and the window counters; dout is held stable; no result is dropped or duplicated.
- Transfer: occurs on dout_vld & dout_rdy. Once the last result transfers, frame_done pulses for one cycle and the FSM returns to IDLE.
- Output count per frame: (IMG_H-2)*(IMG_W-2).
- out_st is asserted together with the first result and held until that result transfers.
- Kernel writes: k_wr takes effect in IDLE or LOAD only. k_addr > 8 is ignored. Writes in CONV are ignored, so the kernel is stable for the whole frame.
- in_st asserted together with the frame_done cycle is ignored; a new frame needs in_st in IDLE.

Optional Feature:
- CONV_PAD_EN defined: zero padding ("same" mode). Output is IMG_H x IMG_W; out-of-frame taps read as 0; scan is r = 0..IMG_H-1, c = 0..IMG_W-1.
- CONV_PAD_EN undefined: "valid" mode only, as described above. No padding logic is present.

Test Plan:
- Default kernel, 8x8 frame of all 1: exactly 36 results, each 128; out_st on the first result; one frame_done pulse.
- Default kernel, all pixels 255: every dout = 32640. With OUT_W=14, every dout = 16383 (saturated).
- Write kernel {0,0,0,0,1,0,0,0,0}, ramp frame din = index: outputs are 9,10,...,14,17,...,54 (the inner 6x6 pixels).
- dout_rdy held low 5 cycles mid-frame: dout stays constant throughout; total 36 results in order, no gaps or duplicates.
- rst asserted after 20 pixels loaded: din_rdy=0 the next cycle, kernel back to default; a following full frame produces correct results.
- in_st and k_wr pulsed during CONV: no effect on results or state; CONV_PAD_EN build with all-1 frame gives corner 72, edge 96, interior 128, 64 results.

Source files
------------

// File: rtl/conv2d_stream.sv
// conv2d_stream: buffers one IMG_H x IMG_W frame, then streams its 3x3 convolution with a runtime-writable kernel.
// Latency: first result 2 cycles after the frame is fully loaded, then one result per cycle.
// Backpressure: din_rdy is high only while loading; dout_vld & !dout_rdy freezes both pipeline stages and the scan.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_st                    frame start pulse, honoured only in IDLE
//   din, din_vld, din_rdy    raster-order pixel stream into the frame buffer
//   k_wr, k_addr, k_data     kernel coefficient write (index 0..8, row-major), IDLE/LOAD only
//   dout, dout_vld, dout_rdy result stream
//   out_st                   marks the first result of a frame
//   frame_done               one-cycle pulse after the last result transfers
//
// Optional: define CONV_PAD_EN for zero-padded "same" mode (IMG_H x IMG_W results).
module conv2d_stream #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int SHIFT  = 0,
   parameter int OUT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_st,
   input  logic [DATA_W-1:0] din,
   input  logic              din_vld,
   output logic              din_rdy,
   input  logic              k_wr,
   input  logic [3:0]        k_addr,
   input  logic [COEF_W-1:0] k_data,
   output logic [OUT_W-1:0]  dout,
   output logic              dout_vld,
   input  logic              dout_rdy,
   output logic              out_st,
   output logic              frame_done
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
`ifdef CONV_PAD_EN
   localparam int R_LAST = IMG_H - 1;
   localparam int C_LAST = IMG_W - 1;
`else
   localparam int R_LAST = IMG_H - 3;
   localparam int C_LAST = IMG_W - 3;
`endif
   localparam int NOUT  = (R_LAST + 1) * (C_LAST + 1);
   localparam int RW    = $clog2(IMG_H + 1);
   localparam int CW    = $clog2(IMG_W + 1);
   localparam int OCW   = $clog2(NOUT + 1);
   localparam int PW    = DATA_W + COEF_W;
   localparam int SUM_W = PW + 4;
   localparam int CMP_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;
   localparam logic [CMP_W-1:0] SAT_MAX = CMP_W'({OUT_W{1'b1}});
   localparam int KDEF [9] = '{8, 16, 8, 16, 32, 16, 8, 16, 8};

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CONV} state_t;

   state_t              state;
   logic [DATA_W-1:0]   mem  [NPIX];
   logic [COEF_W-1:0]   kern [9];
   logic [AW-1:0]       ld_cnt;
   logic [RW-1:0]       r;
   logic [CW-1:0]       c;
   logic                iss_done;   // every window of the frame has entered stage 1
   logic [OCW-1:0]      out_cnt;

   logic [PW-1:0]       prod [9];
   logic                s1_vld;
   logic                s1_first;

   logic [DATA_W-1:0]   tap [9];
   logic [SUM_W-1:0]    sum;
   logic [CMP_W-1:0]    shifted;
   logic [OUT_W-1:0]    sat_val;
   logic                advance;
   int                  rr;
   int                  cc;

   // The whole pipeline moves unless a valid result is waiting on downstream.
   assign advance = !(dout_vld && !dout_rdy);

   // Window taps for the current scan position.
   always_comb begin
      rr = 0;
      cc = 0;
      for (int k = 0; k < 9; k++) tap[k] = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
`ifdef CONV_PAD_EN
            rr = int'(r) + i - 1;
            cc = int'(c) + j - 1;
            if (rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W)
               tap[i*3+j] = mem[AW'(rr * IMG_W + cc)];
            else
               tap[i*3+j] = '0;
`else
            rr = int'(r) + i;
            cc = int'(c) + j;
            tap[i*3+j] = mem[AW'(rr * IMG_W + cc)];
`endif
         end
      end
   end

   // Stage 2 datapath: sum, scale, saturate.
   always_comb begin
      sum = '0;
      for (int k = 0; k < 9; k++) sum = sum + SUM_W'(prod[k]);
      shifted = CMP_W'(sum >> SHIFT);
      sat_val = (shifted > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : shifted[OUT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         din_rdy    <= 1'b0;
         dout_vld   <= 1'b0;
         out_st     <= 1'b0;
         frame_done <= 1'b0;
         dout       <= '0;
         ld_cnt     <= '0;
         r          <= '0;
         c          <= '0;
         iss_done   <= 1'b0;
         out_cnt    <= '0;
         s1_vld     <= 1'b0;
         s1_first   <= 1'b0;
         for (int k = 0; k < 9; k++) begin
            kern[k] <= COEF_W'(KDEF[k]);
            prod[k] <= '0;
         end
      end else begin
         frame_done <= 1'b0;

         // Kernel is frozen during CONV so a frame sees one coefficient set.
         if (k_wr && state != S_CONV && k_addr < 4'd9)
            kern[k_addr] <= k_data;

         case (state)
            S_IDLE: begin
               // frame_done high means we just left CONV; that cycle's in_st is not a new start.
               if (in_st && !frame_done) begin
                  state   <= S_LOAD;
                  din_rdy <= 1'b1;
                  ld_cnt  <= '0;
               end
            end

            S_LOAD: begin
               if (din_vld && din_rdy) begin
                  mem[ld_cnt] <= din;
                  if (ld_cnt == AW'(NPIX - 1)) begin
                     din_rdy  <= 1'b0;
                     state    <= S_CONV;
                     r        <= '0;
                     c        <= '0;
                     iss_done <= 1'b0;
                     out_cnt  <= '0;
                  end else begin
                     ld_cnt <= ld_cnt + 1'b1;
                  end
               end
            end

            S_CONV: begin
               if (advance) begin
                  // Stage 1: issue the next window, if any remain.
                  s1_vld <= !iss_done;
                  if (!iss_done) begin
                     for (int k = 0; k < 9; k++)
                        prod[k] <= PW'(tap[k]) * PW'(kern[k]);
                     s1_first <= (r == '0) && (c == '0);
                     if (c == CW'(C_LAST)) begin
                        c <= '0;
                        if (r == RW'(R_LAST)) iss_done <= 1'b1;
                        else                  r <= r + 1'b1;
                     end else begin
                        c <= c + 1'b1;
                     end
                  end
                  // Stage 2: register the result.
                  dout_vld <= s1_vld;
                  out_st   <= s1_vld && s1_first;
                  if (s1_vld) dout <= sat_val;
               end

               if (dout_vld && dout_rdy) begin
                  if (out_cnt == OCW'(NOUT - 1)) begin
                     frame_done <= 1'b1;
                     state      <= S_IDLE;
                  end else begin
                     out_cnt <= out_cnt + 1'b1;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream: directed sequence of frames with randomized pixels, kernels and backpressure,
// checked against an arithmetic convolution model. A second instance with OUT_W=14 runs in lockstep
// to exercise output saturation.
module tb_conv2d_stream;
   localparam int DATA_W  = 8;
   localparam int COEF_W  = 8;
   localparam int IMG_W   = 8;
   localparam int IMG_H   = 8;
   localparam int SHIFT   = 0;
   localparam int OUT_W   = 16;
   localparam int OUT_W_S = 14;
   localparam int NPIX    = IMG_W * IMG_H;
`ifdef CONV_PAD_EN
   localparam int OH = IMG_H, OW = IMG_W, OFF = 1;
`else
   localparam int OH = IMG_H - 2, OW = IMG_W - 2, OFF = 0;
`endif
   localparam int NOUT = OH * OW;
   localparam int KDEF [9] = '{8, 16, 8, 16, 32, 16, 8, 16, 8};

   logic clk = 1'b0;
   logic rst, in_st, din_vld, k_wr, dout_rdy;
   logic [DATA_W-1:0]  din;
   logic [3:0]         k_addr;
   logic [COEF_W-1:0]  k_data;
   logic               din_rdy, dout_vld, out_st, frame_done;
   logic [OUT_W-1:0]   dout;
   logic               din_rdy_s, dout_vld_s, out_st_s, frame_done_s;
   logic [OUT_W_S-1:0] dout_s;

   int     n_tests = 0;
   int     n_fail  = 0;
   int     pix  [NPIX];
   int     kern [9];
   longint exp_q [$];

   always #5 clk = ~clk;

   conv2d_stream #(.DATA_W(DATA_W), .COEF_W(COEF_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
                   .SHIFT(SHIFT), .OUT_W(OUT_W)) u_dut (
      .clk(clk), .rst(rst), .in_st(in_st), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
      .k_wr(k_wr), .k_addr(k_addr), .k_data(k_data), .dout(dout), .dout_vld(dout_vld),
      .dout_rdy(dout_rdy), .out_st(out_st), .frame_done(frame_done));

   conv2d_stream #(.DATA_W(DATA_W), .COEF_W(COEF_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
                   .SHIFT(SHIFT), .OUT_W(OUT_W_S)) u_sat (
      .clk(clk), .rst(rst), .in_st(in_st), .din(din), .din_vld(din_vld), .din_rdy(din_rdy_s),
      .k_wr(k_wr), .k_addr(k_addr), .k_data(k_data), .dout(dout_s), .dout_vld(dout_vld_s),
      .dout_rdy(dout_rdy), .out_st(out_st_s), .frame_done(frame_done_s));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint sat(input longint v, input int w);
      longint m;
      m = (longint'(1) << w) - 1;
      return (v > m) ? m : v;
   endfunction

   // Reference: direct 3x3 convolution over the stored frame and kernel.
   function automatic void build_expected();
      longint s;
      int rr, cc;
      exp_q.delete();
      for (int r = 0; r < OH; r++) begin
         for (int c = 0; c < OW; c++) begin
            s = 0;
            for (int i = 0; i < 3; i++) begin
               for (int j = 0; j < 3; j++) begin
                  rr = r + i - OFF;
                  cc = c + j - OFF;
                  if (rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W)
                     s += longint'(pix[rr*IMG_W+cc]) * longint'(kern[i*3+j]);
               end
            end
            exp_q.push_back(s >> SHIFT);
         end
      end
   endfunction

   task automatic write_k(input int addr, input int data);
      k_wr   = 1'b1;
      k_addr = 4'(addr);
      k_data = COEF_W'(data);
      tick();
      k_wr = 1'b0;
      if (addr <= 8) kern[addr] = data & ((1 << COEF_W) - 1);
   endtask

   task automatic load_frame(input int stop_at);
      int   i = 0;
      int   guard = 0;
      logic rdy;
      in_st = 1'b1;
      tick();
      in_st = 1'b0;
      check("din_rdy_rise", din_rdy, 1);
      while (i < stop_at && guard < 2000) begin
         din_vld = ($urandom_range(0, 3) != 0);
         din     = DATA_W'(pix[i]);
         rdy     = din_rdy;
         tick();
         guard++;
         if (din_vld && rdy) i++;
      end
      din_vld = 1'b0;
      if (guard >= 2000) check("load_timeout", 0, 1);
   endtask

   task automatic collect(input bit chaos, input bit stall5);
      int   k = 0;
      int   cyc = 0;
      int   st = 0;
      bit   was_stall = 1'b0;
      logic [OUT_W-1:0] held = '0;
      check("din_rdy_drop", din_rdy, 0);
      while (k < NOUT && cyc < 5000) begin
         if (stall5 && k == 10 && st < 5) begin
            dout_rdy = 1'b0;
            if (dout_vld) st++;
         end else if (chaos) begin
            dout_rdy = ($urandom_range(0, 2) != 0);
         end else begin
            dout_rdy = 1'b1;
         end
         if (chaos) begin
            in_st  = ($urandom_range(0, 5) == 0);
            k_wr   = ($urandom_range(0, 3) == 0);
            k_addr = 4'($urandom_range(0, 8));
            k_data = COEF_W'($urandom);
         end
         if (cyc < 2)       check("first_lat_idle", dout_vld, 0);
         else if (cyc == 2) check("first_lat_vld", dout_vld, 1);
         if (was_stall) begin
            check("stall_hold_dat", dout, held);
            check("stall_hold_vld", dout_vld, 1);
         end
         check("frame_done_early", frame_done, 0);
         check("sat_vld_lockstep", dout_vld_s, dout_vld);
         if (dout_vld && dout_rdy) begin
            check("dout", dout, sat(exp_q[k], OUT_W));
            check("dout_sat14", dout_s, sat(exp_q[k], OUT_W_S));
            check("out_st", out_st, k == 0);
            k++;
         end
         was_stall = dout_vld && !dout_rdy;
         held      = dout;
         tick();
         cyc++;
      end
      in_st    = 1'b0;
      k_wr     = 1'b0;
      dout_rdy = 1'b1;
      if (cyc >= 5000) check("collect_timeout", 0, 1);
      check("frame_done_pulse", frame_done, 1);
      check("vld_after_last", dout_vld, 0);
      // A start coinciding with frame_done must not open a new frame.
      in_st = 1'b1;
      tick();
      in_st = 1'b0;
      check("frame_done_clear", frame_done, 0);
      check("in_st_ignored_done", din_rdy, 0);
   endtask

   task automatic run_frame(input bit chaos, input bit stall5);
      build_expected();
      load_frame(NPIX);
      collect(chaos, stall5);
   endtask

   initial begin
      rst = 1'b1; in_st = 1'b0; din = '0; din_vld = 1'b0;
      k_wr = 1'b0; k_addr = '0; k_data = '0; dout_rdy = 1'b1;
      for (int k = 0; k < 9; k++) kern[k] = KDEF[k];
      tick();
      tick();
      check("rst_din_rdy", din_rdy, 0);
      check("rst_dout_vld", dout_vld, 0);
      check("rst_out_st", out_st, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_dout", dout, 0);
      rst = 1'b0;
      tick();
      check("idle_din_rdy", din_rdy, 0);

      // All-ones frame, default kernel.
      for (int i = 0; i < NPIX; i++) pix[i] = 1;
      run_frame(1'b0, 1'b0);

      // All-255 frame: full-scale value and saturation in the narrow instance.
      for (int i = 0; i < NPIX; i++) pix[i] = 255;
      run_frame(1'b0, 1'b0);

      // Identity kernel over a ramp; out-of-range address must be ignored.
      for (int k = 0; k < 9; k++) write_k(k, (k == 4) ? 1 : 0);
      write_k(12, 99);
      for (int i = 0; i < NPIX; i++) pix[i] = i % 256;
      run_frame(1'b0, 1'b0);

      // Random frame and kernel, forced 5-cycle stall, noise on in_st/k_wr during CONV.
      for (int k = 0; k < 9; k++) write_k(k, int'($urandom_range(0, 255)));
      for (int i = 0; i < NPIX; i++) pix[i] = int'($urandom_range(0, 255));
      run_frame(1'b1, 1'b1);

      // Reset part-way through a load: abort and kernel back to default.
      for (int i = 0; i < NPIX; i++) pix[i] = int'($urandom_range(0, 255));
      load_frame(20);
      rst = 1'b1;
      tick();
      check("midrst_din_rdy", din_rdy, 0);
      check("midrst_dout_vld", dout_vld, 0);
      rst = 1'b0;
      for (int k = 0; k < 9; k++) kern[k] = KDEF[k];
      tick();
      run_frame(1'b1, 1'b0);

      // A few more random frames with random kernels and backpressure.
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < 9; k++) write_k(k, int'($urandom_range(0, 63)));
         for (int i = 0; i < NPIX; i++) pix[i] = int'($urandom_range(0, 255));
         run_frame(1'b1, f == 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
